// File: rtl/aurras_audio_pkg.sv
// Shared audio definitions: default sample width, the signed sample type and
// the delay-line sequencer states.
package aurras_audio_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;

  typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

  // One RAM access and one capture per channel, then a single output update.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } dly_state_e;

  // Width of a channel index; a single channel still needs a one-bit field.
  function automatic int ch_index_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Shaped so synthesis maps it onto block RAM.
module delay_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  audio_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and one-cycle registered read port.
  // NOTE: the array and its read register carry no reset; a reset would stop
  // block-RAM inference, and stale contents are masked by the frame counter.
  always_ff @(posedge audio_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/multi_channel_delay.sv
// Multi-channel audio delay line. Each sample frame is latched on the input
// strobe, then the channels are walked in index order through one shared RAM
// (write current sample, read the delayed one), and all outputs update at once.
module multi_channel_delay
  import aurras_audio_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int MAX_DELAY    = 1024,
  parameter int DELAY_WIDTH  = $clog2(MAX_DELAY)
) (
  input  logic                           audio_clk,
  input  logic                           rst_in,
  input  logic                           audio_valid_in,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] audio_in,
  input  logic [NUM_CH*DELAY_WIDTH-1:0]  delay_length,
  input  logic [NUM_CH-1:0]              bypass,
  output logic [NUM_CH*SAMPLE_WIDTH-1:0] audio_out,
  output logic                           audio_valid_out,
  output logic                           busy,
  output logic                           overrun
);

  localparam int CH_W   = ch_index_width(NUM_CH);
  localparam int ADDR_W = CH_W + DELAY_WIDTH;
  localparam int DEPTH  = NUM_CH * MAX_DELAY;
  localparam int CNT_W  = DELAY_WIDTH + 1;

  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DELAY);

  dly_state_e state, next_state;

  logic [CH_W-1:0]         ch;
  logic [DELAY_WIDTH-1:0]  wr_ptr;
  logic [CNT_W-1:0]        frame_cnt;

  // Frame captured on the strobe; stays stable while the channels are walked.
  logic [SAMPLE_WIDTH-1:0] in_q   [NUM_CH];
  logic [DELAY_WIDTH-1:0]  dly_q  [NUM_CH];
  logic [NUM_CH-1:0]       byp_q;
  logic [SAMPLE_WIDTH-1:0] stage_q [NUM_CH];

  logic                    accept;
  logic                    ram_en;
  logic [DELAY_WIDTH-1:0]  rd_ptr;
  logic [ADDR_W-1:0]       ram_wr_addr;
  logic [ADDR_W-1:0]       ram_rd_addr;
  logic [SAMPLE_WIDTH-1:0] ram_wr_data;
  logic [SAMPLE_WIDTH-1:0] ram_rd_data;
  logic                    direct_sel;
  logic                    fill_mask;
  logic [SAMPLE_WIDTH-1:0] capture_data;

  // A strobe starts a frame only when the sequencer is idle.
  assign accept = (state == ST_IDLE) && audio_valid_in;
  assign busy   = (state != ST_IDLE);

  // State register.
  // NOTE: clocked state is updated with non-blocking '<=' so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing: ACCESS/CAPTURE per channel, then one DONE cycle.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (audio_valid_in) next_state = ST_ACCESS;
      ST_ACCESS:  next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = (ch == LAST_CH) ? ST_DONE : ST_ACCESS;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // RAM addressing and capture-source selection for the current channel.
  always_comb begin
    ram_en       = (state == ST_ACCESS);
    rd_ptr       = wr_ptr - dly_q[ch];
    ram_wr_addr  = {ch, wr_ptr};
    ram_rd_addr  = {ch, rd_ptr};
    ram_wr_data  = in_q[ch];
    // Zero delay would read the slot being written this cycle, so take the
    // latched sample directly instead.
    direct_sel   = byp_q[ch] || (dly_q[ch] == '0);
    // Until d frames have been written, the delayed slot holds no valid data.
    fill_mask    = (frame_cnt < {1'b0, dly_q[ch]});
    capture_data = ram_rd_data;
    if (direct_sel) begin
      capture_data = in_q[ch];
    end else if (fill_mask) begin
      capture_data = '0;
    end
  end

  delay_ram #(
    .WIDTH      (SAMPLE_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_W)
  ) u_delay_ram (
    .audio_clk (audio_clk),
    .wr_en     (ram_en),
    .wr_addr   (ram_wr_addr),
    .wr_data   (ram_wr_data),
    .rd_en     (ram_en),
    .rd_addr   (ram_rd_addr),
    .rd_data   (ram_rd_data)
  );

  // Latch the whole input frame on an accepted strobe.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      byp_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        in_q[c]  <= '0;
        dly_q[c] <= '0;
      end
    end else if (accept) begin
      byp_q <= bypass;
      for (int c = 0; c < NUM_CH; c++) begin
        in_q[c]  <= audio_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        dly_q[c] <= delay_length[c*DELAY_WIDTH +: DELAY_WIDTH];
      end
    end
  end

  // Channel index, write pointer, fill counter and the overrun flag.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      ch        <= '0;
      wr_ptr    <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (audio_valid_in && busy) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        ch <= '0;
      end else if (state == ST_CAPTURE && ch != LAST_CH) begin
        ch <= ch + 1'b1;
      end
      if (state == ST_DONE) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (frame_cnt != CNT_MAX) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Stage each channel's result as its read data arrives.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        stage_q[c] <= '0;
      end
    end else if (state == ST_CAPTURE) begin
      stage_q[ch] <= capture_data;
    end
  end

  // Publish all channels together with a one-cycle valid pulse.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      audio_valid_out <= (state == ST_DONE);
      if (state == ST_DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          audio_out[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_q[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_delay.sv
// Directed bench for multi_channel_delay: two channels, 16-sample buffers.
module tb_multi_channel_delay;
  import aurras_audio_pkg::*;

  localparam int NUM_CH = 2;
  localparam int SW     = 16;
  localparam int MAXD   = 16;
  localparam int DW     = 4;

  logic                  audio_clk = 1'b0;
  logic                  rst_in = 1'b0;
  logic                  audio_valid_in = 1'b0;
  logic [NUM_CH*SW-1:0]  audio_in = '0;
  logic [NUM_CH*DW-1:0]  delay_length = '0;
  logic [NUM_CH-1:0]     bypass = '0;
  logic [NUM_CH*SW-1:0]  audio_out;
  logic                  audio_valid_out;
  logic                  busy;
  logic                  overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic    rst;
    sample_t in0, in1;
    int      d0, d1;
    logic    b0, b1;
    sample_t e0, e1;
  } vec_t;

  vec_t vecs[$];

  multi_channel_delay #(
    .NUM_CH       (NUM_CH),
    .SAMPLE_WIDTH (SW),
    .MAX_DELAY    (MAXD)
  ) dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .audio_valid_in  (audio_valid_in),
    .audio_in        (audio_in),
    .delay_length    (delay_length),
    .bypass          (bypass),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 audio_clk = ~audio_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input int in0, input int in1,
                     input int d0, input int d1, input logic b0, input logic b1,
                     input int e0, input int e1);
    vec_t v;
    v.rst = rst;
    v.in0 = sample_t'(in0);
    v.in1 = sample_t'(in1);
    v.d0  = d0;
    v.d1  = d1;
    v.b0  = b0;
    v.b1  = b1;
    v.e0  = sample_t'(e0);
    v.e1  = sample_t'(e1);
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    audio_valid_in = 1'b0;
    rst_in = 1'b0;
    repeat (2) @(negedge audio_clk);
    rst_in = 1'b1;
  endtask

  // One strobe, then wait (bounded) for valid_out; checks busy and latency.
  task automatic run_frame(input int in0, input int in1, input int d0, input int d1,
                           input logic b0, input logic b1, input string tag,
                           output sample_t got0, output sample_t got1);
    int   cyc;
    logic busy_done;
    @(negedge audio_clk);
    audio_in       = {SW'(in1), SW'(in0)};
    delay_length   = {DW'(d1), DW'(d0)};
    bypass         = {b1, b0};
    audio_valid_in = 1'b1;
    @(negedge audio_clk);
    audio_valid_in = 1'b0;
    // Disturb the inputs; the frame in flight must use the latched copy.
    audio_in       = 32'h5A5A_A5A5;
    delay_length   = 8'h99;
    bypass         = ~{b1, b0};
    check({tag, " busy_start"}, 32'(busy), 1);
    cyc = 1;
    busy_done = 1'b0;
    while (!audio_valid_out && cyc < 20) begin
      @(negedge audio_clk);
      cyc++;
      if (cyc == 5) busy_done = busy;
    end
    check({tag, " latency"}, cyc, 6);
    check({tag, " busy_done_cycle"}, 32'(busy_done), 1);
    check({tag, " busy_end"}, 32'(busy), 0);
    got0 = audio_out[SW-1:0];
    got1 = audio_out[2*SW-1:SW];
  endtask

  initial begin
    sample_t g0, g1;
    int      pulses;
    int      pulse_cyc;

    // Ramp through delays 3 and 5.
    add(1,   1,   1, 3, 5, 0, 0,    0,   0);
    add(0,   2,   2, 3, 5, 0, 0,    0,   0);
    add(0,   3,   3, 3, 5, 0, 0,    0,   0);
    add(0,   4,   4, 3, 5, 0, 0,    1,   0);
    add(0,   5,   5, 3, 5, 0, 0,    2,   0);
    add(0,   6,   6, 3, 5, 0, 0,    3,   1);
    add(0,   7,   7, 3, 5, 0, 0,    4,   2);
    add(0,   8,   8, 3, 5, 0, 0,    5,   3);
    // Zero delay on ch0, bypass on ch1: same-frame passthrough.
    add(0, -100,  7, 0, 9, 0, 1, -100,   7);
    // Back to delayed reads; the passthrough frame was still stored.
    add(0,  10,  10, 3, 5, 0, 0,    7,   5);
    add(0,  11,  11, 2, 1, 0, 0, -100,  10);
    // Fresh reset; ch0 delay drops from 4 to 2 at frame 10.
    add(1, 100,  -1, 4, 1, 0, 0,    0,   0);
    add(0, 101,  -2, 4, 1, 0, 0,    0,  -1);
    add(0, 102,  -3, 4, 1, 0, 0,    0,  -2);
    add(0, 103,  -4, 4, 1, 0, 0,    0,  -3);
    add(0, 104,  -5, 4, 1, 0, 0,  100,  -4);
    add(0, 105,  -6, 4, 1, 0, 0,  101,  -5);
    add(0, 106,  -7, 4, 1, 0, 0,  102,  -6);
    add(0, 107,  -8, 4, 1, 0, 0,  103,  -7);
    add(0, 108,  -9, 4, 1, 0, 0,  104,  -8);
    add(0, 109, -10, 4, 1, 0, 0,  105,  -9);
    add(0, 110, -11, 2, 1, 0, 0,  108, -10);
    add(0, 111, -12, 2, 1, 0, 0,  109, -11);

    // Reset values while reset is held.
    repeat (3) @(negedge audio_clk);
    check("reset audio_out", audio_out, 0);
    check("reset valid_out", 32'(audio_valid_out), 0);
    check("reset busy", 32'(busy), 0);
    check("reset overrun", 32'(overrun), 0);
    rst_in = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      run_frame(vecs[i].in0, vecs[i].in1, vecs[i].d0, vecs[i].d1,
                vecs[i].b0, vecs[i].b1, $sformatf("vec%0d", i), g0, g1);
      check($sformatf("vec%0d ch0", i), 32'(g0), 32'(vecs[i].e0));
      check($sformatf("vec%0d ch1", i), 32'(g1), 32'(vecs[i].e1));
    end

    // Long delay across two write-pointer wraps.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      run_frame(i + 1, 1000 + i, 15, 7, 0, 0, $sformatf("wrap%0d", i), g0, g1);
      check($sformatf("wrap%0d ch0", i), 32'(g0), (i < 15) ? 0 : i + 1 - 15);
      check($sformatf("wrap%0d ch1", i), 32'(g1), (i < 7) ? 0 : 1000 + i - 7);
    end

    // Reset during the first CAPTURE cycle of a frame.
    @(negedge audio_clk);
    audio_in = {16'sd500, 16'sd400};
    delay_length = {4'd2, 4'd2};
    bypass = 2'b00;
    audio_valid_in = 1'b1;
    @(negedge audio_clk);
    audio_valid_in = 1'b0;
    @(negedge audio_clk);
    check("midrst busy_before", 32'(busy), 1);
    check("midrst out_before", audio_out, {16'sd1032, 16'sd25});
    #1 rst_in = 1'b0;
    #1;
    check("midrst audio_out", audio_out, 0);
    check("midrst valid_out", 32'(audio_valid_out), 0);
    check("midrst busy", 32'(busy), 0);
    @(negedge audio_clk);
    rst_in = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge audio_clk);
      if (audio_valid_out) pulses++;
    end
    check("midrst no_valid", pulses, 0);
    run_frame(70, 80, 2, 2, 0, 0, "postrst0", g0, g1);
    check("postrst0 ch0", 32'(g0), 0);
    check("postrst0 ch1", 32'(g1), 0);
    run_frame(71, 81, 2, 2, 0, 0, "postrst1", g0, g1);
    check("postrst1 ch0", 32'(g0), 0);
    check("postrst1 ch1", 32'(g1), 0);
    run_frame(72, 82, 2, 2, 0, 0, "postrst2", g0, g1);
    check("postrst2 ch0", 32'(g0), 70);
    check("postrst2 ch1", 32'(g1), 80);

    // Second strobe two cycles after the first.
    check("ovr before", 32'(overrun), 0);
    @(negedge audio_clk);
    audio_in = {16'sd22, 16'sd11};
    delay_length = '0;
    bypass = 2'b00;
    audio_valid_in = 1'b1;
    @(negedge audio_clk);
    audio_valid_in = 1'b0;
    @(negedge audio_clk);
    audio_in = {16'sd44, 16'sd33};
    audio_valid_in = 1'b1;
    @(negedge audio_clk);
    audio_valid_in = 1'b0;
    pulses = 0;
    pulse_cyc = 0;
    g0 = '0;
    g1 = '0;
    for (int c = 3; c < 15; c++) begin
      if (audio_valid_out) begin
        pulses++;
        pulse_cyc = c;
        g0 = audio_out[SW-1:0];
        g1 = audio_out[2*SW-1:SW];
      end
      @(negedge audio_clk);
    end
    check("ovr flag", 32'(overrun), 1);
    check("ovr pulses", pulses, 1);
    check("ovr latency", pulse_cyc, 6);
    check("ovr ch0", 32'(g0), 11);
    check("ovr ch1", 32'(g1), 22);
    run_frame(5, 6, 0, 0, 1, 0, "ovr_next", g0, g1);
    check("ovr_next ch0", 32'(g0), 5);
    check("ovr_next ch1", 32'(g1), 6);
    check("ovr sticky", 32'(overrun), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_delay.md
MULTI_CHANNEL_DELAY -- requirements
Module: multi_channel_delay

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent audio channels, 1..8.
REQ-002 Parameter SAMPLE_WIDTH, default 16, signed sample width.
REQ-003 Parameter MAX_DELAY, default 1024, per-channel buffer depth in samples, power of two; DELAY_WIDTH = clog2(MAX_DELAY).
REQ-004 audio_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_in  in  1  reset, asynchronous, active-low.
REQ-006 audio_valid_in  in  1  one-cycle sample strobe (nominally 24 kHz).
REQ-007 audio_in  in  NUM_CH x SAMPLE_WIDTH  signed input samples, sampled on the strobe.
REQ-008 delay_length  in  NUM_CH x DELAY_WIDTH  per-channel delay in samples.
REQ-009 bypass  in  NUM_CH  per-channel bypass: output = input, no delay.
REQ-010 audio_out  out  NUM_CH x SAMPLE_WIDTH  signed delayed samples, registered.
REQ-011 audio_valid_out  out  1  one-cycle strobe when all audio_out channels update.
REQ-012 busy  out  1  high while a sample frame is in flight.
REQ-013 overrun  out  1  sticky; strobe arrived while busy.

Function
REQ-014 On audio_valid_in with busy low, audio_in, delay_length and bypass SHALL be latched for all channels; later changes affect only the next frame.
REQ-015 FSM states IDLE -> ACCESS -> CAPTURE -> (ACCESS for next channel | DONE) -> IDLE; channels processed in index order 0..NUM_CH-1.
REQ-016 ACCESS: write latched sample of channel c to address {c, wr_ptr}; issue read of {c, (wr_ptr - delay_c) mod MAX_DELAY}.
REQ-017 CAPTURE: take one-cycle RAM read data into the channel's staging register.
REQ-018 DONE: copy all staging registers to audio_out simultaneously, pulse audio_valid_out, increment wr_ptr modulo MAX_DELAY (wraps MAX_DELAY-1 -> 0).
REQ-019 Latency from strobe to audio_valid_out SHALL be exactly 2*NUM_CH+2 cycles; busy high from the cycle after the strobe through the DONE cycle.
REQ-020 delay_length = 0 or bypass high SHALL yield output = that frame's input (no read-before-write hazard).
REQ-021 Delay d in 1..MAX_DELAY-1 SHALL yield output = input from exactly d frames earlier.
REQ-022 Saturating frame counter (saturates at MAX_DELAY): while counter < d, channel output SHALL be 0 (RAM contents never read before written).
REQ-023 Strobe while busy SHALL be ignored, frame in flight unaffected, overrun set; overrun cleared only by reset.
REQ-024 No arithmetic on samples; address arithmetic is unsigned DELAY_WIDTH-bit modular.

Reset
REQ-025 rst_in low SHALL asynchronously force audio_out to 0, audio_valid_out 0, busy 0, overrun 0, wr_ptr 0, frame counter 0, FSM to IDLE.
REQ-026 Reset mid-frame SHALL abort the frame with no audio_valid_out; RAM contents are not cleared (masked by REQ-022).

Structure
REQ-027 Shared package aurras_audio_pkg holds SAMPLE_WIDTH default, signed sample_t typedef and the FSM state enum.
REQ-028 Sub-module delay_ram: simple dual-port, NUM_CH*MAX_DELAY x SAMPLE_WIDTH, one write and one read port, registered read (1-cycle), no reset, BRAM-inferable.

Verification
REQ-029 NUM_CH=2, delays {3,5}, ramp inputs 1,2,3... on both channels -> ch0 outputs 0,0,0,1,2...; ch1 outputs 0x5 then 1,2...; valid_out 6 cycles after each strobe.
REQ-030 delay 0 on ch0 and bypass on ch1, input {-100, 7} -> same frame outputs {-100, 7}.
REQ-031 MAX_DELAY=16, delay 15, 40 frames of ramp -> output n-15 after fill, correct across wr_ptr wraps at frames 16 and 32.
REQ-032 Second strobe 2 cycles after first -> overrun=1, exactly one valid_out, first frame data intact.
REQ-033 Change delay_length 4->2 on frame 10 -> frame 10 output = input from frame 8, no glitch value.
REQ-034 Assert rst_in low during CAPTURE -> outputs 0 immediately, no valid_out; after release with delay 2, first two outputs 0.
